bit_serializer: RTL and testbench
=================================

# bit_serializer

Parallel-to-serial front end for the serial sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per clock on `dout`, which drives the detector's `din` input directly. When idle it drives `dout` low, so the downstream detector always sees a defined bit every cycle. It also flags word boundaries for bench and debug use.

## Interface
- `WIDTH`, default 8: bits per word; legal range ≥ 2.
- `MSB_FIRST`, default 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- `clk`  input  1  clock; all state changes on the rising edge.
- `rst`  input  1  reset; synchronous, active-high.
- `data_in`  input  WIDTH  word to serialize; sampled on the accept cycle.
- `in_valid`  input  1  upstream has a word on `data_in`.
- `in_ready`  output  1  block can take a word this cycle; combinational from registered state only.
- `dout`  output  1  serial bit, registered; 0 whenever `dout_valid` = 0.
- `dout_valid`  output  1  `dout` carries a word bit this cycle, registered.
- `last`  output  1  high with the final bit of each word, registered.

## Operation
- Accept = `in_valid` && `in_ready` at a rising edge. If `in_valid` is high while `in_ready` is low, nothing is captured; upstream holds the word.
- FSM states:
  - IDLE: `in_ready` = 1, `dout_valid` = 0. On accept, load the shift register and set the bit counter to WIDTH-1, then go to SHIFT.
  - SHIFT: each cycle, present the current bit, shift toward the output end, and decrement the counter. The counter = 0 cycle is the last bit.
- On the last bit: go to IDLE if no word is pending; otherwise reload and stay in SHIFT (pending words exist only with the skid option).
- The counter is $clog2(WIDTH) bits wide and is never decremented below 0.
- Reset, including mid-word: go to IDLE and discard any partial word and held word.
- Reset values: `dout` = 0, `dout_valid` = 0, `last` = 0, `in_ready` = 1 from the first cycle after reset.
- If a word is in flight when `rst` is asserted, `dout_valid` drops in the cycle after the reset edge. The remaining bits are never sent.

## Timing
- Accept at edge T: the first bit appears on `dout` in cycle T+1, and bit k appears in cycle T+1+k.
- `last` = 1 only in cycle T+WIDTH.
- Throughput without skid: `in_ready` returns to 1 in cycle T+WIDTH+1. The earliest next first bit is in cycle T+WIDTH+2, which leaves exactly one gap cycle with `dout` = 0 and `dout_valid` = 0.
- Throughput with skid: words stream with no gap cycle; see Configuration.
- The output bit of a given cycle never depends on `in_valid` in that same cycle.

## Configuration
- `SER_SKID_EN` defined: adds a one-word hold register with a full flag.
  - `in_ready` = !hold_full, including in SHIFT.
  - An accept in SHIFT loads the hold register.
  - An accept in the last-bit cycle with the hold register empty bypasses it and loads the shift register directly.
  - On the last bit with hold_full set, the shift register loads from the hold register and hold_full clears. The first bit of that word follows the previous `last` bit in the very next cycle.
  - A held word is output only after the word in flight completes; words are never reordered.
- `SER_SKID_EN` undefined: no hold register, and `in_ready` = (state == IDLE). Behaviour is exactly as in Operation and Timing.

## Test plan
- Reset: hold `rst` for 3 cycles with `in_valid` = 1 → `dout`, `dout_valid` and `last` are all 0; `in_ready` = 1 in the first cycle after release; no word is captured while `rst` is high.
- MSB_FIRST=1, `data_in` = 8'hD0 accepted at T → `dout` = 1,1,0,1,0,0,0,0 in cycles T+1..T+8; `last` only at T+8; with the detector attached, `y` = 1 in cycle T+4 only.
- MSB_FIRST=0, `data_in` = 8'h0B → same serial pattern 1,1,0,1,0,0,0,0.
- `in_valid` held high with 8'hA5 then 8'h3C:
  - Without skid: 8 valid bits, 1 gap cycle, then 8 valid bits.
  - With `SER_SKID_EN`: 16 consecutive `dout_valid` cycles, `last` at bits 8 and 16, and `in_ready` = 0 while the hold register is full.
- `rst` pulsed during the cycle that outputs bit 3 of 8'hFF → `dout_valid` and `dout` are 0 in the next cycle, and `in_ready` = 1. A following word 8'h81 serializes cleanly as 1,0,0,0,0,0,0,1.
- No skid: a word presented with a one-cycle `in_valid` pulse while in SHIFT → it is not captured; the in-flight word completes unchanged and `in_ready` rises after `last`.

Source files
------------

// File: rtl/bit_serializer.sv
// bit_serializer: parallel-to-serial front end, valid/ready in, one registered bit per clock out.
// Define SER_SKID_EN to add a one-word hold register so back-to-back words stream gap-free.
module bit_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             last
);

  // state   | meaning
  // S_IDLE  | no word in flight, dout held low
  // S_SHIFT | word on dout, cnt_q = bits still to follow the current one
  typedef enum logic {S_IDLE, S_SHIFT} state_e;

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             last_q, last_d;
  logic             accept;
`ifdef SER_SKID_EN
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
`endif

  // The shift register always shifts left and emits its MSB; LSB-first words are reversed on load.
  function automatic logic [WIDTH-1:0] orient(input logic [WIDTH-1:0] w);
    logic [WIDTH-1:0] r;
    r = w;
    if (!MSB_FIRST) begin
      for (int i = 0; i < WIDTH; i++) r[i] = w[WIDTH-1-i];
    end
    return r;
  endfunction

  assign accept = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      shreg_q      <= '0;
      cnt_q        <= '0;
      dout_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      last_q       <= 1'b0;
`ifdef SER_SKID_EN
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      last_q       <= last_d;
`ifdef SER_SKID_EN
      hold_q       <= hold_d;
      hold_full_q  <= hold_full_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
`ifdef SER_SKID_EN
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          shreg_d = orient(data_in);
          cnt_d   = CNT_LOAD;
        end
      end
      S_SHIFT: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
`ifdef SER_SKID_EN
          if (accept) begin
            hold_d      = data_in;
            hold_full_d = 1'b1;
          end
`endif
        end else begin
`ifdef SER_SKID_EN
          if (hold_full_q) begin
            shreg_d     = orient(hold_q);
            cnt_d       = CNT_LOAD;
            hold_full_d = 1'b0;
          end else if (accept) begin
            shreg_d = orient(data_in);
            cnt_d   = CNT_LOAD;
          end else begin
            state_d = S_IDLE;
            shreg_d = '0;
          end
`else
          state_d = S_IDLE;
          shreg_d = '0;
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from next-state values so dout never depends on same-cycle in_valid.
  always_comb begin
`ifdef SER_SKID_EN
    in_ready = !hold_full_q;
`else
    in_ready = (state_q == S_IDLE);
`endif
    dout_valid_d = (state_d == S_SHIFT);
    dout_d       = dout_valid_d && shreg_d[WIDTH-1];
    last_d       = dout_valid_d && (cnt_d == '0);
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign last       = last_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: stimulus pushes expected {bit,last}, a negedge monitor pops.
module tb_bit_serializer;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready, dout, dout_valid, last;
  logic [7:0] l_data = 8'h00;
  logic       l_valid = 1'b0;
  logic       l_ready, l_dout, l_dv, l_last;

  int         checks = 0;
  int         errors = 0;
  logic [1:0] sb[$];
  logic       mon_en = 1'b0;

  always #5 clk = ~clk;

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .in_valid(in_valid), .in_ready(in_ready),
    .dout(dout), .dout_valid(dout_valid), .last(last)
  );

  bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .rst(rst), .data_in(l_data), .in_valid(l_valid), .in_ready(l_ready),
    .dout(l_dout), .dout_valid(l_dv), .last(l_last)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected serial stream given MSB-first as it should appear on dout.
  task automatic push_pat(input logic [7:0] pat);
    for (int i = 7; i >= 0; i--) sb.push_back({pat[i], (i == 0)});
  endtask

  always @(negedge clk) begin
    logic [1:0] e;
    if (mon_en) begin
      if (dout_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bit dout=%0b last=%0b expected=none", dout, last);
        end else begin
          e = sb.pop_front();
          check("serial_bit_last", 32'({dout, last}), 32'(e));
        end
      end else begin
        check("idle_outputs_low", 32'({dout, last}), 32'h0);
      end
    end
  end

  // Accept one word (bounded wait), then verify its on-wire timing: T+1..T+8 valid, last at T+8.
  task automatic timed_word(input logic [7:0] w, input logic [7:0] pat);
    int n;
    logic [7:0] dv, ls;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = w;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_wait_bound", 32'(n < 50), 32'h1);
    @(posedge clk);
    push_pat(pat);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      dv[7-k] = dout_valid;
      ls[7-k] = last;
    end
    check("word_valid_window", 32'(dv), 32'hFF);
    check("word_last_position", 32'(ls), 32'h01);
    @(negedge clk);
    check("word_gap_after", 32'(dout_valid), 32'h0);
  endtask

  initial begin
    logic [7:0]  bits, lasts, dvs;
    logic [18:1] vv, rr;
    int          n_acc;

    // Reset held 3 cycles with in_valid high: nothing captured.
    rst      = 1'b1;
    in_valid = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({dout, dout_valid, last}), 32'h0);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("reset_in_ready", 32'(in_ready), 32'h1);
    repeat (3) @(negedge clk);
    check("reset_no_capture", 32'(dout_valid), 32'h0);

    // MSB-first 8'hD0 -> 1,1,0,1,0,0,0,0
    timed_word(8'hD0, 8'hD0);

    // LSB-first 8'h0B -> same serial pattern
    @(negedge clk);
    check("lsb_ready", 32'(l_ready), 32'h1);
    l_valid = 1'b1;
    l_data  = 8'h0B;
    @(posedge clk);
    #1 l_valid = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      bits[7-k]  = l_dout;
      lasts[7-k] = l_last;
      dvs[7-k]   = l_dv;
    end
    check("lsb_bits", 32'(bits), 32'hD0);
    check("lsb_last", 32'(lasts), 32'h01);
    check("lsb_valid", 32'(dvs), 32'hFF);
    repeat (2) @(negedge clk);

    // in_valid held high: 8'hA5 then 8'h3C
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 8'hA5;
    check("stream_ready0", 32'(in_ready), 32'h1);
    @(posedge clk);
    push_pat(8'hA5);
    n_acc = 1;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      vv[c] = dout_valid;
      rr[c] = in_ready;
      if (n_acc == 1) begin
        data_in = 8'h3C;
        if (in_ready) begin
          push_pat(8'h3C);
          n_acc = 2;
        end
      end else begin
        in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
`ifdef SER_SKID_EN
    check("stream_valid_pattern", 32'(vv), 32'({2'b00, 16'hFFFF}));
    check("stream_ready_pattern", 32'(rr), 32'({10'h3FF, 7'h00, 1'b1}));
`else
    check("stream_valid_pattern", 32'(vv), 32'({1'b0, 8'hFF, 1'b0, 8'hFF}));
    check("stream_ready_pattern", 32'(rr), 32'({1'b1, 8'h00, 1'b1, 8'h00}));
`endif
    repeat (2) @(negedge clk);

    // Reset pulsed during the cycle carrying bit 3 of 8'hFF
    @(negedge clk);
    check("midrst_ready", 32'(in_ready), 32'h1);
    in_valid = 1'b1;
    data_in  = 8'hFF;
    @(posedge clk);
    push_pat(8'hFF);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    @(negedge clk);
    check("midrst_outputs", 32'({dout, dout_valid}), 32'h0);
    check("midrst_in_ready", 32'(in_ready), 32'h1);
    timed_word(8'h81, 8'h81);

    // One-cycle in_valid pulse while a word is in flight
    @(negedge clk);
    in_valid = 1'b1;
    data_in  = 8'h5A;
    @(posedge clk);
    push_pat(8'h5A);
    #1 in_valid = 1'b0;
    repeat (2) @(negedge clk);
    in_valid = 1'b1;
    data_in  = 8'hC3;
`ifdef SER_SKID_EN
    check("pulse_ready_during", 32'(in_ready), 32'h1);
    push_pat(8'hC3);
`else
    check("pulse_ready_during", 32'(in_ready), 32'h0);
`endif
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("pulse_last_at_end", 32'({dout_valid, last}), 32'h3);
    @(negedge clk);
    check("pulse_ready_after", 32'(in_ready), 32'h1);
`ifdef SER_SKID_EN
    check("pulse_next_valid", 32'(dout_valid), 32'h1);
`else
    check("pulse_next_valid", 32'(dout_valid), 32'h0);
`endif
    repeat (12) @(negedge clk);

    check("scoreboard_drained", 32'(sb.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
